// File: rtl/mem_initiator_if.sv
// rtl/mem_initiator_if.sv - request/response channels and memory pins of mem_initiator
interface mem_initiator_if #(
   parameter int ADDR_WIDTH = 2,
   parameter int DATA_WIDTH = 8
);
   // request channel (driver -> initiator)
   logic                  req_valid;
   logic                  req_ready;
   logic                  req_write;
   logic [ADDR_WIDTH-1:0] req_addr;
   logic [DATA_WIDTH-1:0] req_wdata;

   // response channel (initiator -> driver), reads only
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [ADDR_WIDTH-1:0] rsp_addr;
   logic [DATA_WIDTH-1:0] rsp_rdata;

   // single-port memory pins
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic                  mem_wr_en;
   logic                  mem_rd_en;
   logic [DATA_WIDTH-1:0] mem_wdata;
   logic [DATA_WIDTH-1:0] mem_rdata;

   // the initiator itself: slave on the request channel, drives the memory
   modport slave (
      input  req_valid, req_write, req_addr, req_wdata,
      input  rsp_ready, mem_rdata,
      output req_ready, rsp_valid, rsp_addr, rsp_rdata,
      output mem_addr, mem_wr_en, mem_rd_en, mem_wdata
   );

   // the requesting side, which also owns the memory model
   modport master (
      output req_valid, req_write, req_addr, req_wdata,
      output rsp_ready, mem_rdata,
      input  req_ready, rsp_valid, rsp_addr, rsp_rdata,
      input  mem_addr, mem_wr_en, mem_rd_en, mem_wdata
   );
endinterface

// File: rtl/mem_initiator.sv
// rtl/mem_initiator.sv - valid/ready command front end for a one-cycle-latency single-port memory
module mem_initiator #(
   parameter int ADDR_WIDTH  = 2,
   parameter int DATA_WIDTH  = 8,
   parameter int COUNT_WIDTH = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   mem_initiator_if.slave         bus,
   output logic                   busy,
   output logic [COUNT_WIDTH-1:0] wr_count,
   output logic [COUNT_WIDTH-1:0] rd_count
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WRITE   = 3'd1,
      READ    = 3'd2,
      CAPTURE = 3'd3,
      RESP    = 3'd4
   } state_t;

   localparam logic [COUNT_WIDTH-1:0] COUNT_ONE = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

   state_t state;
   state_t state_next;

   // registered memory pins; address and data keep their last value between pulses
   logic [ADDR_WIDTH-1:0]  mem_addr_q;
   logic [DATA_WIDTH-1:0]  mem_wdata_q;
   logic                   mem_wr_en_q;
   logic                   mem_rd_en_q;

   // registered response channel
   logic                   rsp_valid_q;
   logic [ADDR_WIDTH-1:0]  rsp_addr_q;
   logic [DATA_WIDTH-1:0]  rsp_rdata_q;

   logic [COUNT_WIDTH-1:0] wr_count_q;
   logic [COUNT_WIDTH-1:0] rd_count_q;

   // decoded handshakes for the current cycle
   logic req_fire;
   logic rsp_fire;

   // state register; reset drops any transaction in flight straight back to IDLE
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // next-state decode and handshake qualification
   always_comb begin
      state_next = state;
      req_fire   = 1'b0;
      rsp_fire   = 1'b0;
      case (state)
         IDLE: begin
            if (bus.req_valid) begin
               req_fire   = 1'b1;
               state_next = bus.req_write ? WRITE : READ;
            end
         end
         WRITE: begin
            state_next = IDLE;
         end
         READ: begin
            state_next = CAPTURE;
         end
         CAPTURE: begin
            state_next = RESP;
         end
         RESP: begin
            // rsp_valid is always high in RESP, so rsp_ready alone completes it
            if (bus.rsp_ready) begin
               rsp_fire   = 1'b1;
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // memory pin drive: one-cycle enable pulses launched from the accepting IDLE cycle
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_wr_en_q <= 1'b0;
         mem_rd_en_q <= 1'b0;
      end else begin
         if (req_fire) begin
            mem_addr_q <= bus.req_addr;
            if (bus.req_write) begin
               mem_wdata_q <= bus.req_wdata;
               mem_wr_en_q <= 1'b1;
            end else begin
               mem_rd_en_q <= 1'b1;
            end
         end
         // the memory samples the enable at the end of WRITE/READ, so drop it there
         if (state == WRITE) begin
            mem_wr_en_q <= 1'b0;
         end
         if (state == READ) begin
            mem_rd_en_q <= 1'b0;
         end
      end
   end

   // response capture: rdata is valid during CAPTURE and is held until consumed
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rsp_valid_q <= 1'b0;
         rsp_addr_q  <= '0;
         rsp_rdata_q <= '0;
      end else begin
         if (state == CAPTURE) begin
            rsp_valid_q <= 1'b1;
            rsp_addr_q  <= mem_addr_q;
            rsp_rdata_q <= bus.mem_rdata;
         end else if (rsp_fire) begin
            rsp_valid_q <= 1'b0;
         end
      end
   end

   // completion counters; a write counts when its pulse finishes, a read on response handshake
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_count_q <= '0;
         rd_count_q <= '0;
      end else begin
         if (state == WRITE) begin
            wr_count_q <= wr_count_q + COUNT_ONE;
         end
         if (rsp_fire) begin
            rd_count_q <= rd_count_q + COUNT_ONE;
         end
      end
   end

   assign bus.req_ready = (state == IDLE);
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_addr  = rsp_addr_q;
   assign bus.rsp_rdata = rsp_rdata_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.mem_wr_en = mem_wr_en_q;
   assign bus.mem_rd_en = mem_rd_en_q;

   assign busy     = (state != IDLE);
   assign wr_count = wr_count_q;
   assign rd_count = rd_count_q;

endmodule

// File: tb/tb_mem_initiator.sv
// tb/tb_mem_initiator.sv - scoreboard bench for mem_initiator with a one-cycle-latency memory model
module tb_mem_initiator;

   localparam int AW = 2;
   localparam int DW = 8;
   localparam int CW = 4;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   mem_initiator_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   logic          busy;
   logic [CW-1:0] wr_count;
   logic [CW-1:0] rd_count;

   mem_initiator #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .COUNT_WIDTH(CW)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .bus     (bus.slave),
      .busy    (busy),
      .wr_count(wr_count),
      .rd_count(rd_count)
   );

   // single-port memory: powers up / resets to 0xFF, rdata registered one cycle after rd_en
   logic [DW-1:0] mem_arr [0:(1<<AW)-1];
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < (1<<AW); k++) mem_arr[k] <= 8'hFF;
         bus.mem_rdata <= '0;
      end else begin
         if (bus.mem_wr_en) mem_arr[bus.mem_addr] <= bus.mem_wdata;
         if (bus.mem_rd_en) bus.mem_rdata <= mem_arr[bus.mem_addr];
      end
   end

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // enable pulses: never overlapping, never longer than one cycle
   logic prev_wr = 1'b0;
   logic prev_rd = 1'b0;
   always @(negedge clk) begin
      if (!reset) begin
         chk("en_excl", 32'(bus.mem_wr_en & bus.mem_rd_en), 0);
         chk("wr_single", 32'(bus.mem_wr_en & prev_wr), 0);
         chk("rd_single", 32'(bus.mem_rd_en & prev_rd), 0);
      end
      prev_wr <= bus.mem_wr_en;
      prev_rd <= bus.mem_rd_en;
   end

   typedef struct {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } rsp_t;
   rsp_t sb [$];

   logic [DW-1:0] ref_mem [0:(1<<AW)-1];
   logic [CW-1:0] exp_wr;
   logic [CW-1:0] exp_rd;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ready(input string tag);
      int n = 0;
      while (!bus.req_ready && n < 50) begin
         step();
         n++;
      end
      if (n >= 50) chk({tag, "_timeout"}, 0, 1);
   endtask

   task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input bit hold);
      bus.req_valid = 1'b1;
      bus.req_write = 1'b1;
      bus.req_addr  = a;
      bus.req_wdata = d;
      wait_ready("wr_ready");
      chk("wr_ready_hi", 32'(bus.req_ready), 1);
      step();
      if (!hold) bus.req_valid = 1'b0;
      chk("wr_en_hi", 32'(bus.mem_wr_en), 1);
      chk("wr_addr", 32'(bus.mem_addr), 32'(a));
      chk("wr_data", 32'(bus.mem_wdata), 32'(d));
      chk("wr_ready_lo", 32'(bus.req_ready), 0);
      chk("wr_busy", 32'(busy), 1);
      step();
      ref_mem[a] = d;
      exp_wr = exp_wr + 1'b1;
      chk("wr_en_lo", 32'(bus.mem_wr_en), 0);
      chk("wr_count", 32'(wr_count), 32'(exp_wr));
      chk("wr_ready_back", 32'(bus.req_ready), 1);
   endtask

   task automatic do_read(input logic [AW-1:0] a, input int stall);
      int n;
      rsp_t e;
      logic [DW-1:0] held;
      bus.req_valid = 1'b1;
      bus.req_write = 1'b0;
      bus.req_addr  = a;
      wait_ready("rd_ready");
      step();
      bus.req_valid = 1'b0;
      sb.push_back('{addr: a, data: ref_mem[a]});
      chk("rd_en_hi", 32'(bus.mem_rd_en), 1);
      chk("rd_addr", 32'(bus.mem_addr), 32'(a));
      bus.rsp_ready = (stall == 0);
      n = 0;
      while (!bus.rsp_valid && n < 20) begin
         step();
         n++;
      end
      chk("rsp_latency", 32'(n + 1), 3);
      held = bus.rsp_rdata;
      for (int s = 0; s < stall; s++) begin
         chk("stall_valid", 32'(bus.rsp_valid), 1);
         chk("stall_rdata", 32'(bus.rsp_rdata), 32'(held));
         chk("stall_ready", 32'(bus.req_ready), 0);
         chk("stall_busy", 32'(busy), 1);
         step();
      end
      bus.rsp_ready = 1'b1;
      if (sb.size() == 0) begin
         chk("sb_empty", 1, 0);
      end else begin
         e = sb.pop_front();
         chk("rsp_addr", 32'(bus.rsp_addr), 32'(e.addr));
         chk("rsp_rdata", 32'(bus.rsp_rdata), 32'(e.data));
      end
      step();
      bus.rsp_ready = 1'b0;
      exp_rd = exp_rd + 1'b1;
      chk("rsp_valid_lo", 32'(bus.rsp_valid), 0);
      chk("rd_count", 32'(rd_count), 32'(exp_rd));
      chk("rd_ready_back", 32'(bus.req_ready), 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset         = 1'b1;
      bus.req_valid = 1'b0;
      bus.req_write = 1'b0;
      bus.req_addr  = '0;
      bus.req_wdata = '0;
      bus.rsp_ready = 1'b0;
      exp_wr = '0;
      exp_rd = '0;
      for (int k = 0; k < (1<<AW); k++) ref_mem[k] = 8'hFF;
      repeat (3) step();
      chk("rst_req_ready", 32'(bus.req_ready), 1);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
      chk("rst_wr_en", 32'(bus.mem_wr_en), 0);
      chk("rst_rd_en", 32'(bus.mem_rd_en), 0);
      chk("rst_wr_count", 32'(wr_count), 0);
      chk("rst_rd_count", 32'(rd_count), 0);
      reset = 1'b0;
      step();

      // fresh memory reads back 0xFF
      do_read(2'd1, 0);

      // write then read the same location
      do_write(2'd2, 8'hA5, 1'b0);
      do_read(2'd2, 0);

      // back-to-back writes with req_valid held, then ordered reads
      for (int i = 0; i < 4; i++) do_write(AW'(i), DW'((i + 1) * 17), i < 3);
      for (int i = 0; i < 4; i++) do_read(AW'(i), 0);

      // consumer stall on the response
      do_read(2'd3, 5);

      // reset while the read data is being captured
      bus.req_valid = 1'b1;
      bus.req_write = 1'b0;
      bus.req_addr  = 2'd1;
      wait_ready("cap_ready");
      step();
      bus.req_valid = 1'b0;
      step();
      chk("cap_busy", 32'(busy), 1);
      reset = 1'b1;
      #1;
      chk("cap_rst_busy", 32'(busy), 0);
      chk("cap_rst_ready", 32'(bus.req_ready), 1);
      chk("cap_rst_valid", 32'(bus.rsp_valid), 0);
      chk("cap_rst_wr", 32'(wr_count), 0);
      chk("cap_rst_rd", 32'(rd_count), 0);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("cap_no_valid", 32'(bus.rsp_valid), 0);
      end
      reset = 1'b0;
      exp_wr = '0;
      exp_rd = '0;
      for (int k = 0; k < (1<<AW); k++) ref_mem[k] = 8'hFF;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("post_rst_valid", 32'(bus.rsp_valid), 0);
      end
      do_read(2'd1, 0);

      // counter wrap at 16 with a 4-bit counter
      for (int i = 0; i < 17; i++) begin
         do_write(AW'(i), DW'(8'h40 + i), 1'b0);
         if (i == 15) chk("wrap_16", 32'(wr_count), 0);
         if (i == 16) chk("wrap_17", 32'(wr_count), 1);
      end
      for (int i = 0; i < 4; i++) do_read(AW'(i), i);

      chk("sb_drained", 32'(sb.size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
